// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous-read video RAM between
// fixed-timing 4x4-scaled scanout (160x120 x 3-bit) and a req/ack host port.
// Video owns every decision cycle; the host gets all remaining cycles.
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic        display_on,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [14:0] host_addr,
    input  logic [2:0]  host_wdata,
    output logic        host_ack,
    output logic [2:0]  host_rdata,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [2:0]  mem_wdata,
    input  logic [2:0]  mem_rdata,
    output logic [2:0]  rgb
);

    localparam logic [9:0] H_FETCH_LIM = 10'(H_ACTIVE - 4);
    localparam logic [9:0] H_PREFETCH  = 10'(H_TOTAL - 4);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} host_st_t;

    // Registered RAM command; what the RAM sees one cycle after the decision.
    typedef struct packed {
        logic [14:0] addr;
        logic        we;
        logic [2:0]  wdata;
    } mem_cmd_t;

    host_st_t   state, state_nxt;
    mem_cmd_t   cmd_q;
    logic       grant;
    logic       op_we;
    logic [2:0] next_pix, pix_reg;

    // Video decision: one fetch per 4-pixel block, one block ahead of the beam,
    // plus column 0 of the next line fetched from the end of horizontal blanking.
    logic [9:0]  nv;
    logic        vid_line, vid_pre, vid_dec;
    logic [7:0]  row, col;
    logic [14:0] vid_addr;

    assign nv       = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    assign vid_line = (hpos[1:0] == 2'd0) && (hpos < H_FETCH_LIM) && (vpos < V_ACT);
    assign vid_pre  = (hpos == H_PREFETCH) && (nv < V_ACT);
    assign vid_dec  = vid_line || vid_pre;
    assign row      = vid_pre ? nv[9:2] : vpos[9:2];
    assign col      = vid_pre ? 8'd0 : hpos[9:2] + 8'd1;
    // row*160 as shift-add; max 119*160+159 = 19199
    assign vid_addr = ({7'd0, row} << 7) + ({7'd0, row} << 5) + {7'd0, col};

    assign mem_addr  = cmd_q.addr;
    assign mem_we    = cmd_q.we;
    assign mem_wdata = cmd_q.wdata;
    assign rgb       = display_on ? pix_reg : 3'd0;

    // Host FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Host FSM next state; grant only in IDLE and never in a video decision cycle.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        host_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (host_req && !vid_dec) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK: begin
                host_ack  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port register: video first, then host grant; address holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q <= '0;
            op_we <= 1'b0;
        end else if (vid_dec) begin
            cmd_q.addr <= vid_addr;
            cmd_q.we   <= 1'b0;
        end else if (grant) begin
            cmd_q.addr  <= host_addr;
            cmd_q.we    <= host_we;
            cmd_q.wdata <= host_wdata;
            op_we       <= host_we;
        end else begin
            cmd_q.we <= 1'b0;
        end
    end

    // Host read data lands two cycles after grant and is held until the next read.
    always_ff @(posedge clk) begin
        if (reset)                          host_rdata <= 3'd0;
        else if (state == CAPTURE && !op_we) host_rdata <= mem_rdata;
    end

    // Pixel pipeline: capture fetched block, then hand it to the beam at the block edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            next_pix <= 3'd0;
            pix_reg  <= 3'd0;
        end else begin
            if (hpos[1:0] == 2'd2) next_pix <= mem_rdata;
            if (hpos[1:0] == 2'd3) pix_reg  <= next_pix;
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port, synchronous-read video RAM between fixed-timing display scanout and a host requester. It consumes the raster position from `hvsync_generator`, prefetches one 4x4-scaled pixel ahead of the beam, and drives `rgb`. The 160x120 framebuffer holds 3-bit `{b,g,r}` pixels. Host accesses use a req/ack handshake in every cycle not reserved for video.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, pixel clocks per line; hpos runs 0..H_TOTAL-1
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, lines per frame; vpos runs 0..V_TOTAL-1
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hpos  in  10  raster column from hvsync_generator
- vpos  in  10  raster line from hvsync_generator
- display_on  in  1  active-video flag from hvsync_generator
- host_req  in  1  host request; level, held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req=1
- host_addr  in  15  word address; stable while host_req=1
- host_wdata  in  3  write pixel; stable while host_req=1
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  3  read data; valid in the ack cycle, held until the next read completes
- mem_addr  out  15  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  3  RAM write data, registered
- mem_rdata  in  3  RAM read data; valid the cycle after its address is presented
- rgb  out  3  `{b,g,r}` pixel output

## Operation
- RAM presentation: the arbiter makes a "decision" in cycle t. The chosen address and we are registered, so the RAM sees them in t+1 and read data is on mem_rdata in t+2.
- Video decision cycles (video always wins):
  - hpos[1:0]==0, hpos<H_ACTIVE-4, vpos<V_ACTIVE: address = (vpos>>2)*160 + (hpos>>2) + 1.
  - hpos==H_TOTAL-4 (796): nv = (vpos==V_TOTAL-1) ? 0 : vpos+1. If nv<V_ACTIVE, address = (nv>>2)*160 (column 0 of the next line). Otherwise no fetch.
  - Row multiply is shift-add (row<<7)+(row<<5); the maximum address is 19199.
- Video data path:
  - mem_rdata is captured into next_pix at the end of the hpos[1:0]==2 cycle.
  - next_pix is copied to pix_reg at the end of the hpos[1:0]==3 cycle.
  - rgb = display_on ? pix_reg : 0, combinational on display_on.
- Host FSM states: IDLE, ISSUE, CAPTURE, ACK.
  - IDLE: if host_req=1 and the cycle is not a video decision cycle, register host_addr, host_we and host_wdata onto the mem port and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: the RAM performs the host access. Go to CAPTURE.
  - CAPTURE: if it is a read, load mem_rdata into host_rdata. Go to ACK.
  - ACK: host_ack=1. Return to IDLE.
  - host_req is sampled only in IDLE. For back-to-back transfers the requester updates its fields at the edge ending the ack cycle.
- mem_we is 1 only in the cycle the host write is presented; it is 0 for video and idle cycles. mem_addr holds its last value when idle.
- Host addresses are passed through unchanged. Addresses 19200..32767 are off-screen scratch and never scanned out.

## Timing
- Reset: state=IDLE; mem_addr=0, mem_we=0, mem_wdata=0, host_ack=0, host_rdata=0, next_pix=0, pix_reg=0. rgb is therefore 0.
- Host latency:
  - Grant in cycle t, mem presented in t+1, host_ack in t+3.
  - A collision with a video decision cycle delays the grant by exactly 1 cycle (video cycles are never adjacent).
  - Peak throughput is 1 transfer per 4 cycles.
- Video latency: the block displayed at hpos 4k..4k+3 is fetched at decision cycle hpos=4k-4, or at hpos=796 for k=0.
- Reset mid-transaction:
  - The FSM returns to IDLE and no host_ack is issued; the host must reissue.
  - A write already registered onto the mem port (reset during ISSUE) still completes in RAM.
- Blanking: no video decisions occur for vpos≥V_ACTIVE, except the hpos=796 prefetch when vpos=V_TOTAL-1. All other cycles are available to the host.

## Test plan
- Reset for 2 cycles with host_req=1 → all outputs 0, mem_we=0; host_ack stays 0 while reset is high.
- vpos=500, host write addr=0x0005, wdata=3'b101, req in cycle t → mem_addr=5, mem_we=1, mem_wdata=5 in t+1; mem_we=0 in t+2; host_ack=1 only in t+3.
- vpos=0, host_req rising at hpos=8 → video presents mem_addr=3 at hpos=9, host presents its address at hpos=10, host_ack at hpos=12 (1 cycle late).
- RAM row 0 preloaded with word k = k mod 8; frame runs → at vpos=0..3, rgb = k mod 8 for hpos 4k..4k+3. rgb=0 whenever display_on=0.
- Next-line prefetch at hpos=796 → vpos=3 presents 160; vpos=524 presents 0; vpos=479 makes no video access (host granted in that cycle).
- Host read of addr 19199 preloaded with 3'b110 → host_rdata=6 in the ack cycle, still 6 after req drops. Reset asserted during ISSUE → no ack, FSM in IDLE.
